// File: rtl/seg7_pkg.sv
// Shared constants and types for the 8-digit seven-segment scan controller.
// Segment patterns are active low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [7:0] AN_OFF    = 8'hFF;

   // 0-9 then A,b,C,d,E,F so out-of-range BCD still renders a hex glyph
   localparam logic [0:15][6:0] SEG_TABLE = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic {
      GUARD = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low seven-segment pattern lookup.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of an 8-digit common-anode display with per-slot
// anti-ghost guard, brightness PWM and a once-per-frame input snapshot.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   GUARD | all anodes off at the start of a slot
//   DRIVE | digit idx lit for the first ON_LEN cycles, dark for the rest
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int DIGIT_HZ     = 8_000,
   parameter int GUARD_CYCLES = 1_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] digits_in,
   input  logic [7:0]  digit_en,
   input  logic [7:0]  dp_in,
   input  logic [2:0]  bright,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick
);

   localparam int SLOT_LEN  = CLK_HZ / DIGIT_HZ;
   localparam int DRIVE_LEN = SLOT_LEN - GUARD_CYCLES;
   localparam int CW        = $clog2(SLOT_LEN);

   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_LEN - 1);
   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
   localparam logic [CW-1:0] GUARD_LEN  = CW'(GUARD_CYCLES);

   if (GUARD_CYCLES < 1 || GUARD_CYCLES >= SLOT_LEN || DRIVE_LEN < 8) begin : g_bad_params
      $error("seg7_scan_ctrl: GUARD_CYCLES must be in [1, SLOT) and leave at least 8 drive cycles");
   end

   scan_state_t   r_state,  w_nxt_state;
   logic [CW-1:0] r_cnt,    w_nxt_cnt;
   logic [2:0]    r_idx,    w_nxt_idx;
   logic [CW-1:0] r_on_len, w_nxt_on_len;
   logic          r_run;
   logic          w_snap;
   logic [CW-1:0] w_on_len_new;
   logic [CW-1:0] w_drv_pos;

   logic [31:0]   r_sh_digits;
   logic [7:0]    r_sh_en;
   logic [7:0]    r_sh_dp;

   logic [3:0]    w_nibble;
   logic [6:0]    w_dec_seg;
   logic [7:0]    w_nxt_an;
   logic [6:0]    w_nxt_seg;
   logic          w_nxt_dp;

   logic [7:0]    r_an;
   logic [6:0]    r_seg;
   logic          r_dp;
   logic          r_frame_tick;

   assign w_on_len_new = CW'(((int'(bright) + 1) * DRIVE_LEN) >> 3);

   // First edge after reset release only takes the snapshot; the slot
   // counter starts from there so every frame is exactly 8 slots long.
   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_cnt    = r_cnt;
      w_nxt_idx    = r_idx;
      w_nxt_on_len = r_on_len;
      w_snap       = 1'b0;
      if (!r_run) begin
         w_snap = 1'b1;
      end else begin
         w_nxt_cnt = r_cnt + CNT_ONE;
         case (r_state)
            GUARD: begin
               if (r_cnt == GUARD_LAST) begin
                  w_nxt_state  = DRIVE;
                  w_nxt_on_len = w_on_len_new;
               end
            end
            DRIVE: begin
               if (r_cnt == CNT_LAST) begin
                  w_nxt_state = GUARD;
                  w_nxt_cnt   = '0;
                  w_nxt_idx   = r_idx + 3'd1;
                  w_snap      = (r_idx == 3'd7);
               end
            end
         endcase
      end
   end

   assign w_nibble  = r_sh_digits[{w_nxt_idx, 2'b00} +: 4];
   assign w_drv_pos = w_nxt_cnt - GUARD_LEN;

   seg7_decode u_decode (
      .i_nibble (w_nibble),
      .o_seg    (w_dec_seg)
   );

   // Outputs are computed from the next position so anode and segments
   // land on the same edge as the state they belong to.
   always_comb begin
      w_nxt_an  = AN_OFF;
      w_nxt_seg = SEG_BLANK;
      w_nxt_dp  = 1'b1;
      if (w_nxt_state == DRIVE && w_drv_pos < w_nxt_on_len && r_sh_en[w_nxt_idx]) begin
         w_nxt_an  = ~(8'd1 << w_nxt_idx);
         w_nxt_seg = w_dec_seg;
         w_nxt_dp  = ~r_sh_dp[w_nxt_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= GUARD;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_on_len     <= '0;
         r_run        <= 1'b0;
         r_sh_digits  <= '0;
         r_sh_en      <= '0;
         r_sh_dp      <= '0;
         r_an         <= AN_OFF;
         r_seg        <= SEG_BLANK;
         r_dp         <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_cnt        <= w_nxt_cnt;
         r_idx        <= w_nxt_idx;
         r_on_len     <= w_nxt_on_len;
         r_run        <= 1'b1;
         r_frame_tick <= w_snap;
         if (w_snap) begin
            r_sh_digits <= digits_in;
            r_sh_en     <= digit_en;
            r_sh_dp     <= dp_in;
         end
         r_an  <= w_nxt_an;
         r_seg <= w_nxt_seg;
         r_dp  <= w_nxt_dp;
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = r_dp;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: per-cycle expected outputs are queued
// by the stimulus and popped/compared by a negedge monitor.
module tb_seg7_scan_ctrl;

   typedef struct packed {
      logic [7:0]  an;
      logic [6:0]  seg;
      logic        dp;
      logic        tick;
      logic [15:0] id;
   } exp_t;

   localparam logic [7:0] AN_SEL [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
   localparam logic [6:0] F1_SEG [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
   localparam logic [6:0] F3_SEG [8] = '{7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   localparam logic [6:0] F5_SEG [2] = '{7'h78, 7'h02};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] digits_in;
   logic [7:0]  digit_en;
   logic [7:0]  dp_in;
   logic [2:0]  bright;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_tick;

   int   checks = 0;
   int   errors = 0;
   int   push_cnt = 0;
   int   cur_edge = 0;
   exp_t exp_q[$];

   seg7_scan_ctrl #(
      .CLK_HZ       (1000),
      .DIGIT_HZ     (100),
      .GUARD_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digits_in  (digits_in),
      .digit_en   (digit_en),
      .dp_in      (dp_in),
      .bright     (bright),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic push_one(input logic [7:0] a, input logic [6:0] s, input logic d, input logic t);
      exp_t e;
      e.an = a; e.seg = s; e.dp = d; e.tick = t; e.id = 16'(push_cnt);
      push_cnt++;
      exp_q.push_back(e);
   endtask

   // One slot: 2 guard cycles then 8 drive cycles, lit for the first 'on'.
   task automatic push_slot(input int k, input logic [6:0] sv, input logic en, input logic dpb,
                            input int on, input logic first, input int n);
      for (int j = 0; j < n; j++) begin
         if (j >= 2 && en && (j - 2) < on)
            push_one(AN_SEL[k], sv, ~dpb, 1'b0);
         else
            push_one(8'hFF, 7'h7F, 1'b1, (j == 0) && first);
      end
   endtask

   task automatic goto_edge(input int t);
      repeat (t - cur_edge) @(posedge clk);
      cur_edge = t;
      #1;
   endtask

   task automatic check_direct(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if ({an, seg, dp, frame_tick} !== {e.an, e.seg, e.dp, e.tick}) begin
            errors++;
            $display("FAIL out[%0d] actual an=%h seg=%h dp=%b tick=%b required an=%h seg=%h dp=%b tick=%b",
                     e.id, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.tick);
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      digits_in = 32'h76543210;
      digit_en  = 8'hFF;
      dp_in     = 8'h00;
      bright    = 3'd7;

      repeat (3) @(posedge clk);
      #1;
      push_one(8'hFF, 7'h7F, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      cur_edge = 0;
      push_cnt = 0;

      push_one(8'hFF, 7'h7F, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++)
         push_slot(k, F1_SEG[k], 1'b1, 1'b0, 8, k == 0, 10);
      for (int k = 0; k < 8; k++)
         push_slot(k, 7'h10, k < 3, k == 2, 8, k == 0, 10);
      for (int k = 0; k < 8; k++)
         push_slot(k, F3_SEG[k], 1'b1, (k == 0) || (k == 7), (k <= 3) ? 1 : 4, k == 0, 10);
      for (int k = 0; k < 6; k++)
         push_slot(k, F3_SEG[k], 1'b1, (k == 0), 4, k == 0, (k == 5) ? 3 : 10);

      goto_edge(35);
      digits_in = 32'h99999999;
      digit_en  = 8'h07;
      dp_in     = 8'h04;

      goto_edge(150);
      digits_in = 32'hFEDCBA98;
      digit_en  = 8'hFF;
      dp_in     = 8'h81;
      bright    = 3'd0;

      goto_edge(194);
      bright = 3'd3;

      goto_edge(294);
      check_direct("queue_drained_pre_reset", 16'(exp_q.size()), 16'd0);
      check_direct("an_before_reset", {8'h00, an}, {8'h00, 8'hDF});
      check_direct("seg_before_reset", {9'h000, seg}, {9'h000, 7'h21});
      #1;
      rst_n = 1'b0;
      #1;
      check_direct("an_async_reset", {8'h00, an}, {8'h00, 8'hFF});
      check_direct("seg_async_reset", {9'h000, seg}, {9'h000, 7'h7F});
      check_direct("dp_tick_async_reset", {14'h0, dp, frame_tick}, {14'h0, 1'b1, 1'b0});

      digits_in = 32'h01234567;
      digit_en  = 8'hFF;
      dp_in     = 8'h00;
      bright    = 3'd7;
      @(posedge clk);
      #1;
      push_cnt = 1000;
      push_one(8'hFF, 7'h7F, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_one(8'hFF, 7'h7F, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++)
         push_slot(k, F5_SEG[k], 1'b1, 1'b0, 8, k == 0, 10);

      for (int i = 0; i < 200 && exp_q.size() > 0; i++)
         @(negedge clk);
      check_direct("queue_drained_end", 16'(exp_q.size()), 16'd0);
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
